// File: rtl/sap_display_pkg.sv
// ---------------------------------------------------------------------------
// sap_display_pkg
// Shared definitions for the SAP output display block:
//   - 7-segment codes for BCD digits 0-9 plus the blank code ({g,f,e,d,c,b,a})
//   - conversion state enum (IDLE / SHIFT / COMMIT)
//   - digit count and shift-register geometry for the double-dabble engine
//   - dabble_step(): one "add 3 to nibbles >= 5, then shift left" iteration
// Optional build macro used by the block: SAP_DISP_BLANK_EN (leading-zero
// blanking, see sap_output_display.sv).
// ---------------------------------------------------------------------------
package sap_display_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int BIN_W      = 8;
    localparam int SH_W       = 4 * NUM_DIGITS + BIN_W;

    localparam logic [6:0] SEG_CODE_0 = 7'h3F;
    localparam logic [6:0] SEG_CODE_1 = 7'h06;
    localparam logic [6:0] SEG_CODE_2 = 7'h5B;
    localparam logic [6:0] SEG_CODE_3 = 7'h4F;
    localparam logic [6:0] SEG_CODE_4 = 7'h66;
    localparam logic [6:0] SEG_CODE_5 = 7'h6D;
    localparam logic [6:0] SEG_CODE_6 = 7'h7D;
    localparam logic [6:0] SEG_CODE_7 = 7'h07;
    localparam logic [6:0] SEG_CODE_8 = 7'h7F;
    localparam logic [6:0] SEG_CODE_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK  = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Shift register layout: {hundreds, tens, ones, binary}. Correct every
    // BCD nibble first, then shift the whole register left by one.
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] t;
        t = sh;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (t[BIN_W + 4*d +: 4] >= 4'd5) begin
                t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/sap_output_display_seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational BCD to 7-segment decoder, active-high segments {g,f,e,d,c,b,a}.
// Ports:
//   bcd_i   [3:0]  BCD digit; codes above 9 decode to blank
//   blank_i        forces the blank pattern regardless of bcd_i
//   seg_o   [6:0]  segment pattern
// ---------------------------------------------------------------------------
module seg7_decoder
    import sap_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_CODE_0;
                4'd1:    seg_o = SEG_CODE_1;
                4'd2:    seg_o = SEG_CODE_2;
                4'd3:    seg_o = SEG_CODE_3;
                4'd4:    seg_o = SEG_CODE_4;
                4'd5:    seg_o = SEG_CODE_5;
                4'd6:    seg_o = SEG_CODE_6;
                4'd7:    seg_o = SEG_CODE_7;
                4'd8:    seg_o = SEG_CODE_8;
                4'd9:    seg_o = SEG_CODE_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sap_output_display.sv
// ---------------------------------------------------------------------------
// sap_output_display
// Consumer of the SAP output register. Captures RESULT on every LO edge,
// converts it to three BCD digits with a sequential shift-and-add-3 engine
// (one shift per clock) and drives a time-multiplexed 3-digit 7-segment
// display. Captures are queued one deep: a running conversion is never
// disturbed, and the most recent capture is the one converted next.
// Ports:
//   CLK           system clock, rising edge
//   CLR_BAR       asynchronous active-low reset
//   LO            output-register load strobe
//   RESULT        value from the output register
//   SEG      [6] registered segments {g,f,e,d,c,b,a}, active-high
//   DIGIT_EN [2] registered one-hot digit enable (bit0 ones, bit2 hundreds)
//   BUSY          conversion in progress
//   DONE          one-cycle pulse when new digits are committed
// Build macro: SAP_DISP_BLANK_EN blanks leading zeros (hundreds, then tens);
// the ones digit is always shown.
// ---------------------------------------------------------------------------
module sap_output_display
    import sap_display_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 16
) (
    input  logic             CLK,
    input  logic             CLR_BAR,
    input  logic             LO,
    input  logic [WIDTH-1:0] RESULT,
    output logic [6:0]       SEG,
    output logic [2:0]       DIGIT_EN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(WIDTH - 1);

    // Conversion path
    conv_state_e       state_q;
    logic              pend_q;
    logic [WIDTH-1:0]  pend_val_q;
    logic [SH_W-1:0]   sh_q;
    logic [2:0]        bit_cnt_q;
    logic [11:0]       disp_q;     // {hundreds, tens, ones}
    logic              done_q;

    // Scan path
    logic [CNT_W-1:0]  scan_cnt_q;
    logic [2:0]        digit_en_q;
    logic [2:0]        digit_en_d;
    logic [6:0]        seg_q;
    logic [6:0]        seg_d;
    logic [3:0]        sel_nib;
    logic              blank;
    logic              scan_tc;

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            disp_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Capture has priority over the IDLE consume below, so an LO on
            // the consuming edge leaves the new value pending.
            if (LO) begin
                pend_val_q <= RESULT;
                pend_q     <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        state_q   <= SHIFT;
                        sh_q      <= {{(4*NUM_DIGITS){1'b0}}, pend_val_q};
                        bit_cnt_q <= '0;
                        if (!LO) begin
                            pend_q <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    sh_q      <= dabble_step(sh_q);
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_q  <= sh_q[SH_W-1:BIN_W];
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan: rotate the enable at terminal count and decode the digit that the
    // new enable selects, so SEG and DIGIT_EN always change together.
    assign scan_tc    = (scan_cnt_q == SCAN_LAST);
    assign digit_en_d = (digit_en_q == 3'b000) ? 3'b001
                                               : {digit_en_q[1:0], digit_en_q[2]};

    always_comb begin
        case (digit_en_d)
            3'b001:  sel_nib = disp_q[3:0];
            3'b010:  sel_nib = disp_q[7:4];
            default: sel_nib = disp_q[11:8];
        endcase
    end

`ifdef SAP_DISP_BLANK_EN
    logic hund_zero;
    logic tens_zero;
    assign hund_zero = (disp_q[11:8] == 4'd0);
    assign tens_zero = (disp_q[7:4] == 4'd0);
    assign blank     = (digit_en_d[2] & hund_zero)
                     | (digit_en_d[1] & hund_zero & tens_zero);
`else
    assign blank = 1'b0;
`endif

    seg7_decoder u_dec (
        .bcd_i   (sel_nib),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            scan_cnt_q <= '0;
            digit_en_q <= 3'b000;
            seg_q      <= SEG_BLANK;
        end else if (scan_tc) begin
            scan_cnt_q <= '0;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    assign SEG      = seg_q;
    assign DIGIT_EN = digit_en_q;
    assign BUSY     = (state_q != IDLE);
    assign DONE     = done_q;

endmodule

// File: tb/tb_sap_output_display.sv
// ---------------------------------------------------------------------------
// tb_sap_output_display
// Self-checking bench for sap_output_display with SCAN_DIV=4. A behavioural
// model (decimal digits by division, a countdown per conversion, a one-deep
// pending slot and a scan position counter) predicts SEG/DIGIT_EN/BUSY/DONE
// every cycle; directed scenarios add fixed expected patterns.
// ---------------------------------------------------------------------------
module tb_sap_output_display;

    localparam int SD = 4;

    logic       CLK     = 1'b0;
    logic       CLR_BAR = 1'b0;
    logic       LO      = 1'b0;
    logic [7:0] RESULT  = 8'd0;
    logic [6:0] SEG;
    logic [2:0] DIGIT_EN;
    logic       BUSY;
    logic       DONE;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    sap_output_display #(.WIDTH(8), .SCAN_DIV(SD)) dut (
        .CLK      (CLK),
        .CLR_BAR  (CLR_BAR),
        .LO       (LO),
        .RESULT   (RESULT),
        .SEG      (SEG),
        .DIGIT_EN (DIGIT_EN),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Expected pattern of digit position pos (0 ones, 1 tens, 2 hundreds).
    function automatic logic [6:0] exp_seg_of(input int val, input int pos);
        int d;
        d = (pos == 0) ? val % 10 : (pos == 1) ? (val / 10) % 10 : val / 100;
`ifdef SAP_DISP_BLANK_EN
        if ((pos == 2 && val < 100) || (pos == 1 && val < 10)) return 7'h00;
`endif
        return seg_tab[d];
    endfunction

    // ---------------- reference model ----------------
    int         m_disp = 0;
    int         m_left = 0;
    int         m_cval = 0;
    int         m_pend = 0;
    int         m_pval = 0;
    int         m_cnt  = 0;
    int         m_pos  = -1;
    logic [6:0] m_seg  = 7'h00;
    logic [2:0] m_den  = 3'b000;
    logic       m_done = 1'b0;
    logic       m_busy = 1'b0;

    initial begin
        forever begin
            @(posedge CLK or negedge CLR_BAR);
            if (!CLR_BAR) begin
                m_disp = 0; m_left = 0; m_cval = 0; m_pend = 0; m_pval = 0;
                m_cnt = 0; m_pos = -1; m_seg = 7'h00; m_den = 3'b000;
                m_done = 1'b0; m_busy = 1'b0;
            end else begin
                // scan sees the display as it was before this edge
                if (m_cnt == SD - 1) begin
                    m_cnt = 0;
                    m_pos = (m_pos + 1) % 3;
                    m_den = 3'(1 << m_pos);
                    m_seg = exp_seg_of(m_disp, m_pos);
                end else begin
                    m_cnt++;
                end
                m_done = 1'b0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_disp = m_cval;
                        m_done = 1'b1;
                    end
                end else if (m_pend != 0) begin
                    m_cval = m_pval;
                    m_left = 9;
                    m_pend = 0;
                end
                if (LO) begin
                    m_pend = 1;
                    m_pval = int'(RESULT);
                end
                m_busy = (m_left > 0);
            end
        end
    end

    // Collects the pattern shown on each digit over three fresh rotations.
    task automatic scan_display(output logic [6:0] g0, output logic [6:0] g1,
                                output logic [6:0] g2, output bit ok);
        logic [2:0] prev;
        int seen;
        g0 = 'x; g1 = 'x; g2 = 'x; seen = 0; prev = DIGIT_EN;
        for (int c = 0; c < 4 * SD && seen < 3; c++) begin
            @(negedge CLK);
            if (DIGIT_EN !== prev) begin
                prev = DIGIT_EN;
                seen++;
                case (DIGIT_EN)
                    3'b001:  g0 = SEG;
                    3'b010:  g1 = SEG;
                    3'b100:  g2 = SEG;
                    default: ;
                endcase
            end
        end
        ok = (seen >= 3);
    endtask

    task automatic test_reset();
        logic [2:0] exp_den;
        repeat (3) @(negedge CLK);
        n_chk++;
        if ({SEG, DIGIT_EN, BUSY, DONE} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: SEG=%h DIGIT_EN=%b BUSY=%b DONE=%b, expected all 0",
                     SEG, DIGIT_EN, BUSY, DONE);
        end
        CLR_BAR = 1'b1;
        for (int k = 1; k <= 5 * SD; k++) begin
            @(negedge CLK);
            exp_den = (k < SD) ? 3'b000 : 3'(1 << (((k / SD) - 1) % 3));
            n_chk++;
            if (DIGIT_EN !== exp_den) begin
                n_fail++;
                $display("FAIL scan_sequence k=%0d: DIGIT_EN=%b expected %b", k, DIGIT_EN, exp_den);
            end
            n_chk++;
            if (SEG !== m_seg || BUSY !== m_busy || DONE !== m_done) begin
                n_fail++;
                $display("FAIL scan_model k=%0d: SEG=%h BUSY=%b DONE=%b expected SEG=%h BUSY=%b DONE=%b",
                         k, SEG, BUSY, DONE, m_seg, m_busy, m_done);
            end
        end
    endtask

    task automatic test_convert();
        int vals[7];
        logic [20:0] dir_exp[3];
        logic [6:0] g0, g1, g2;
        bit ok;
        int v;
        vals = '{255, 0, 7, 0, 0, 0, 0};
        for (int i = 3; i < 7; i++) vals[i] = int'($urandom_range(0, 255));
        dir_exp[0] = {7'h5B, 7'h6D, 7'h6D};
`ifdef SAP_DISP_BLANK_EN
        dir_exp[1] = {7'h00, 7'h00, 7'h3F};
        dir_exp[2] = {7'h00, 7'h00, 7'h07};
`else
        dir_exp[1] = {7'h3F, 7'h3F, 7'h3F};
        dir_exp[2] = {7'h3F, 7'h3F, 7'h07};
`endif
        for (int i = 0; i < 7; i++) begin
            v = vals[i];
            for (int c = 0; c <= 12; c++) begin
                @(negedge CLK);
                n_chk++;
                if (SEG !== m_seg || DIGIT_EN !== m_den || BUSY !== m_busy || DONE !== m_done) begin
                    n_fail++;
                    $display("FAIL convert_model v=%0d c=%0d: SEG=%h DEN=%b BUSY=%b DONE=%b expected %h %b %b %b",
                             v, c, SEG, DIGIT_EN, BUSY, DONE, m_seg, m_den, m_busy, m_done);
                end
                n_chk++;
                if (DONE !== (c == 11)) begin
                    n_fail++;
                    $display("FAIL convert_done v=%0d c=%0d: DONE=%b expected %b", v, c, DONE, (c == 11));
                end
                n_chk++;
                if (BUSY !== (c >= 2 && c <= 10)) begin
                    n_fail++;
                    $display("FAIL convert_busy v=%0d c=%0d: BUSY=%b expected %b", v, c, BUSY, (c >= 2 && c <= 10));
                end
                LO = (c == 0);
                if (c == 0) RESULT = 8'(v);
            end
            scan_display(g0, g1, g2, ok);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL convert_scan_timeout v=%0d: fewer than 3 rotations, expected 3", v);
            end
            n_chk++;
            if (g0 !== exp_seg_of(v, 0) || g1 !== exp_seg_of(v, 1) || g2 !== exp_seg_of(v, 2)) begin
                n_fail++;
                $display("FAIL convert_digits v=%0d: got %h %h %h expected %h %h %h", v, g2, g1, g0,
                         exp_seg_of(v, 2), exp_seg_of(v, 1), exp_seg_of(v, 0));
            end
            if (i < 3) begin
                n_chk++;
                if ({g2, g1, g0} !== dir_exp[i]) begin
                    n_fail++;
                    $display("FAIL convert_directed v=%0d: got %h %h %h expected %h %h %h", v, g2, g1, g0,
                             dir_exp[i][20:14], dir_exp[i][13:7], dir_exp[i][6:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] prev;
        logic [6:0] e;
        logic [6:0] g0, g1, g2;
        logic [20:0] exp99;
        bit ok;
        int ndone;
        ndone = 0;
        prev = DIGIT_EN;
        for (int c = 0; c <= 22; c++) begin
            @(negedge CLK);
            n_chk++;
            if (SEG !== m_seg || DIGIT_EN !== m_den || BUSY !== m_busy || DONE !== m_done) begin
                n_fail++;
                $display("FAIL b2b_model c=%0d: SEG=%h DEN=%b BUSY=%b DONE=%b expected %h %b %b %b",
                         c, SEG, DIGIT_EN, BUSY, DONE, m_seg, m_den, m_busy, m_done);
            end
            n_chk++;
            if (DONE !== (c == 11 || c == 21)) begin
                n_fail++;
                $display("FAIL b2b_done c=%0d: DONE=%b expected %b", c, DONE, (c == 11 || c == 21));
            end
            if (DONE === 1'b1) ndone++;
            // between the two commits the display must show 128
            if (c >= 12 && c <= 21 && DIGIT_EN !== prev) begin
                e = (DIGIT_EN == 3'b001) ? 7'h7F : (DIGIT_EN == 3'b010) ? 7'h5B : 7'h06;
                n_chk++;
                if (SEG !== e) begin
                    n_fail++;
                    $display("FAIL b2b_first_value c=%0d: SEG=%h on DIGIT_EN=%b expected %h", c, SEG, DIGIT_EN, e);
                end
            end
            prev = DIGIT_EN;
            LO = (c == 0 || c == 3 || c == 5);
            RESULT = (c == 0) ? 8'd128 : (c == 3) ? 8'd42 : (c == 5) ? 8'd99 : 8'($urandom);
        end
        n_chk++;
        if (ndone != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d pulses expected 2", ndone);
        end
        scan_display(g0, g1, g2, ok);
`ifdef SAP_DISP_BLANK_EN
        exp99 = {7'h00, 7'h6F, 7'h6F};
`else
        exp99 = {7'h3F, 7'h6F, 7'h6F};
`endif
        n_chk++;
        if (!ok || {g2, g1, g0} !== exp99) begin
            n_fail++;
            $display("FAIL b2b_second_value: got %h %h %h expected %h %h %h", g2, g1, g0,
                     exp99[20:14], exp99[13:7], exp99[6:0]);
        end
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 70; c++) begin
            @(negedge CLK);
            n_chk++;
            if (SEG !== m_seg || DIGIT_EN !== m_den || BUSY !== m_busy || DONE !== m_done) begin
                n_fail++;
                $display("FAIL random_model c=%0d: SEG=%h DEN=%b BUSY=%b DONE=%b expected %h %b %b %b",
                         c, SEG, DIGIT_EN, BUSY, DONE, m_seg, m_den, m_busy, m_done);
            end
            LO = (c < 40) && ($urandom_range(0, 3) == 0);
            RESULT = 8'($urandom);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] g0, g1, g2;
        logic [20:0] exp0;
        bit ok;
        int ndone;
        ndone = 0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge CLK);
            n_chk++;
            if (SEG !== m_seg || DIGIT_EN !== m_den || BUSY !== m_busy || DONE !== m_done) begin
                n_fail++;
                $display("FAIL rstmid_model c=%0d: SEG=%h DEN=%b BUSY=%b DONE=%b expected %h %b %b %b",
                         c, SEG, DIGIT_EN, BUSY, DONE, m_seg, m_den, m_busy, m_done);
            end
            LO = (c == 0);
            RESULT = (c == 0) ? 8'd200 : 8'($urandom);
        end
        #1 CLR_BAR = 1'b0;
        #1;
        n_chk++;
        if ({SEG, DIGIT_EN, BUSY, DONE} !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_async: SEG=%h DIGIT_EN=%b BUSY=%b DONE=%b expected all 0",
                     SEG, DIGIT_EN, BUSY, DONE);
        end
        repeat (2) @(negedge CLK);
        CLR_BAR = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            n_chk++;
            if (SEG !== m_seg || DIGIT_EN !== m_den || BUSY !== m_busy || DONE !== m_done) begin
                n_fail++;
                $display("FAIL rstmid_resume c=%0d: SEG=%h DEN=%b BUSY=%b DONE=%b expected %h %b %b %b",
                         c, SEG, DIGIT_EN, BUSY, DONE, m_seg, m_den, m_busy, m_done);
            end
            if (DONE === 1'b1) ndone++;
        end
        n_chk++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d pulses expected 0", ndone);
        end
        scan_display(g0, g1, g2, ok);
`ifdef SAP_DISP_BLANK_EN
        exp0 = {7'h00, 7'h00, 7'h3F};
`else
        exp0 = {7'h3F, 7'h3F, 7'h3F};
`endif
        n_chk++;
        if (!ok || {g2, g1, g0} !== exp0) begin
            n_fail++;
            $display("FAIL rstmid_display: got %h %h %h expected %h %h %h", g2, g1, g0,
                     exp0[20:14], exp0[13:7], exp0[6:0]);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
